player_input_ctrl: RTL

//   Conditions the two raw player push-buttons and the VGA vertical sync into the

---
 rtl/player_input_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/player_input_ctrl.sv
// player_input_ctrl
// Turns the two raw player push-buttons and the active-low VGA vertical sync
// into frame-aligned move requests. Each button is synchronised and debounced
// by its own small FSM. Left+right held together cancels to no movement.
// A one-cycle frame tick fires on each vsync assertion. The resolved requests
// are latched on that tick, so the position stage sees stable inputs all frame.

module player_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_WIDTH       = 18
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Btn_Left_Raw,
  input  logic i_Btn_Right_Raw,
  input  logic i_VSync,
  output logic o_Btn_Left,
  output logic o_Btn_Right,
  output logic o_fTick,
  output logic o_Left_Db,
  output logic o_Right_Db
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Index 0 is the left button, index 1 is the right button.
  logic [1:0]           btn_meta;
  logic [1:0]           btn_sync;
  logic                 vs_meta;
  logic                 vs_sync;
  logic                 vs_prev;
  logic                 vs_fall;
  db_state_t            state_q [2];
  db_state_t            state_d [2];
  logic [CNT_WIDTH-1:0] cnt_q   [2];
  logic [CNT_WIDTH-1:0] cnt_d   [2];
  logic [1:0]           db_q;
  logic [1:0]           db_d;
  logic                 req_left;
  logic                 req_right;

  // Two-flop synchronisers. Vsync idles high, so its flops reset high; this keeps reset release from looking like a vsync fall.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      btn_meta <= 2'b00;
      btn_sync <= 2'b00;
      vs_meta  <= 1'b1;
      vs_sync  <= 1'b1;
    end else begin
      btn_meta <= {i_Btn_Right_Raw, i_Btn_Left_Raw};
      btn_sync <= btn_meta;
      vs_meta  <= i_VSync;
      vs_sync  <= vs_meta;
    end
  end

  // Debounce state, stability counters and debounced levels for both buttons.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      db_q <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      db_q <= db_d;
    end
  end

  // Debounce next-state logic: a new level must hold for DEBOUNCE_CYCLES cycles; any bounce restarts the wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      case (state_q[i])
        IDLE: begin
          if (btn_sync[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!btn_sync[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_sync[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      db_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_WAIT);
    end
  end

  assign o_Left_Db  = db_q[0];
  assign o_Right_Db = db_q[1];

  // A left+right conflict cancels both requests.
  assign req_left  = db_q[0] & ~db_q[1];
  assign req_right = db_q[1] & ~db_q[0];
  assign vs_fall   = vs_prev & ~vs_sync;

  // Frame tick on vsync fall. Requests latch from debounced levels that settled before this edge.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      vs_prev     <= 1'b1;
      o_fTick     <= 1'b0;
      o_Btn_Left  <= 1'b0;
      o_Btn_Right <= 1'b0;
    end else begin
      vs_prev <= vs_sync;
      o_fTick <= vs_fall;
      if (vs_fall) begin
        o_Btn_Left  <= req_left;
        o_Btn_Right <= req_right;
      end
    end
  end

endmodule
